// File: rtl/sha_controller_param.sv
`default_nettype none
// ============================================================================
// Module      : sha_controller_param
// Description : Multi-block SHA-256 sequencing FSM (load, round, update, drain)
//               with valid/ready message input, back-pressured digest output,
//               block counting and synchronous abort.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_controller_param #(
    parameter  int LOAD_WORDS = 16,
    parameter  int ROUNDS     = 64,
    parameter  int OUT_WORDS  = 8,
    parameter  int BLKCNT_W   = 16,
    localparam int LW = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1,
    localparam int RW = (ROUNDS > 1)     ? $clog2(ROUNDS)     : 1,
    localparam int OW = (OUT_WORDS > 1)  ? $clog2(OUT_WORDS)  : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                abort_i,
    input  logic                blk_start_i,
    input  logic                blk_last_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic                load_en_o,
    output logic [LW-1:0]       word_idx_o,
    output logic                round_en_o,
    output logic [RW-1:0]       round_idx_o,
    output logic                first_block_core_o,
    output logic                update_en_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OW-1:0]       out_idx_o,
    output logic                done_o,
    output logic                busy_o,
    output logic [BLKCNT_W-1:0] blk_count_o
);

    localparam logic [LW-1:0] LW_LAST = LW'(LOAD_WORDS - 1);
    localparam logic [RW-1:0] RW_LAST = RW'(ROUNDS - 1);
    localparam logic [OW-1:0] OW_LAST = OW'(OUT_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_UPDATE = 3'd3,
        S_WAIT   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         word_idx_q, word_idx_d;
    logic [RW-1:0]         round_idx_q, round_idx_d;
    logic [OW-1:0]         out_idx_q, out_idx_d;
    logic                  last_q, last_d;
    logic                  first_q, first_d;
    logic                  done_q, done_d;
    logic [BLKCNT_W-1:0]   blk_count_q, blk_count_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            round_idx_q <= '0;
            out_idx_q   <= '0;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            round_idx_q <= round_idx_d;
            out_idx_q   <= out_idx_d;
            last_q      <= last_d;
            first_q     <= first_d;
            done_q      <= done_d;
            blk_count_q <= blk_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        round_idx_d = round_idx_q;
        out_idx_d   = out_idx_q;
        last_d      = last_q;
        first_d     = first_q;
        done_d      = 1'b0;
        blk_count_d = blk_count_q;

        case (state_q)
            S_IDLE: begin
                if (blk_start_i) begin
                    last_d      = blk_last_i;
                    first_d     = 1'b1;
                    blk_count_d = '0;
                    word_idx_d  = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid_i) begin
                    if (word_idx_q == LW_LAST) begin
                        word_idx_d  = '0;
                        round_idx_d = '0;
                        state_d     = S_ROUND;
                    end else begin
                        word_idx_d = word_idx_q + LW'(1);
                    end
                end
            end
            S_ROUND: begin
                if (round_idx_q == RW_LAST) begin
                    round_idx_d = '0;
                    state_d     = S_UPDATE;
                end else begin
                    round_idx_d = round_idx_q + RW'(1);
                end
            end
            S_UPDATE: begin
                if (blk_count_q != {BLKCNT_W{1'b1}}) begin
                    blk_count_d = blk_count_q + BLKCNT_W'(1);
                end
                first_d   = 1'b0;
                out_idx_d = '0;
                state_d   = last_q ? S_OUT : S_WAIT;
            end
            S_WAIT: begin
                if (blk_start_i) begin
                    last_d     = blk_last_i;
                    word_idx_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    if (out_idx_q == OW_LAST) begin
                        out_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + OW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything except the block counter, kept for inspection.
        if (abort_i) begin
            state_d     = S_IDLE;
            word_idx_d  = '0;
            round_idx_d = '0;
            out_idx_d   = '0;
            last_d      = 1'b0;
            first_d     = 1'b0;
            done_d      = 1'b0;
            blk_count_d = blk_count_q;
        end
    end

    assign in_ready_o         = (state_q == S_LOAD);
    assign load_en_o          = in_valid_i && in_ready_o;
    assign word_idx_o         = word_idx_q;
    assign round_en_o         = (state_q == S_ROUND);
    assign round_idx_o        = round_idx_q;
    assign first_block_core_o = round_en_o && (round_idx_q == '0) && first_q;
    assign update_en_o        = (state_q == S_UPDATE);
    assign out_valid_o        = (state_q == S_OUT);
    assign out_idx_o          = out_idx_q;
    assign done_o             = done_q;
    assign busy_o             = (state_q != S_IDLE);
    assign blk_count_o        = blk_count_q;

endmodule
`default_nettype wire
